mmio_responder: RTL and testbench



---
 rtl/mmio_pkg.sv | 57 +++++
 rtl/sw_debounce.sv | 48 ++++
 rtl/mmio_responder.sv | 146 ++++++++++++++
 tb/tb_mmio_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped I/O responder.
//   - bus command encodings, I/O window addresses, responder FSM states
//   - seven-segment blank constant and hex-digit glyph decoder (active-low)
package mmio_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned LED_W  = 8;
    localparam int unsigned SW_W   = 8;
    localparam int unsigned SEG_W  = 7;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10,
        MRSVD  = 2'b11
    } mem_cmd_e;

    localparam logic [ADDR_W-1:0] ADDR_LEDR   = 9'h100;
    localparam logic [ADDR_W-1:0] ADDR_HEX    = 9'h120;
    localparam logic [ADDR_W-1:0] ADDR_SW     = 9'h140;
    localparam logic [ADDR_W-1:0] ADDR_CYCLES = 9'h180;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] seg7_decode(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by a stability counter.
//   clk, reset_n : clock, synchronous active-low reset
//   sw_raw       : asynchronous switch inputs
//   sw_stable    : value accepted after DEBOUNCE_CYCLES equal consecutive
//                  synchronised samples (2 + DEBOUNCE_CYCLES cycles after a change)
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned W               = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] sw_raw,
    output logic [W-1:0] sw_stable
);

    localparam int unsigned          CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  sample_prev;
    logic [CW-1:0] cnt;

    // Counter restarts on any sample change; it saturates at CNT_LAST, and the
    // step onto CNT_LAST is the moment the sample is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            sample_prev <= '0;
            cnt         <= '0;
            sw_stable   <= '0;
        end else begin
            sync1       <= sw_raw;
            sync2       <= sync1;
            sample_prev <= sync2;
            if (sync2 != sample_prev) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
                if (cnt + CW'(1) == CNT_LAST) begin
                    sw_stable <= sync2;
                end
            end
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: responder for CPU loads/stores to the I/O window (addr[8]=1).
//   clk, reset_n         : clock, synchronous active-low reset
//   mem_cmd/mem_addr     : CPU command (00 none, 01 read, 10 write, 11 = none)
//   write_data           : store data
//   SW                   : raw switches (debounced internally)
//   read_data, rd_valid  : load response, valid one cycle after the read
//   io_sel               : combinational mem_addr[8], selects read_data at top
//   LEDR, HEX0..HEX3     : board outputs
// Build option MMIO_HEX_DECODE_EN: when defined HEX0..HEX3 show the nibbles of
// the 0x120 register as glyphs; otherwise they are blanked (register remains).
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [SW_W-1:0]   SW,
    output logic [DATA_W-1:0] read_data,
    output logic              io_sel,
    output logic              rd_valid,
    output logic [LED_W-1:0]  LEDR,
    output logic [SEG_W-1:0]  HEX0,
    output logic [SEG_W-1:0]  HEX1,
    output logic [SEG_W-1:0]  HEX2,
    output logic [SEG_W-1:0]  HEX3
);

    state_e            state;
    logic [SW_W-1:0]   sw_stable;
    logic [DATA_W-1:0] hex_reg;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [DATA_W-1:0] rd_mux;
    logic              io_read;
    logic              io_write;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .W              (SW_W)
    ) u_sw_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_raw   (SW),
        .sw_stable(sw_stable)
    );

    assign io_sel   = mem_addr[ADDR_W-1];
    assign io_read  = io_sel && (mem_cmd == MREAD);
    assign io_write = io_sel && (mem_cmd == MWRITE);

    // Read value of the addressed register; unmapped I/O addresses read zero.
    always_comb begin
        rd_mux = '0;
        case (mem_addr)
            ADDR_LEDR:   rd_mux = DATA_W'(LEDR);
            ADDR_HEX:    rd_mux = hex_reg;
            ADDR_SW:     rd_mux = DATA_W'(sw_stable);
            ADDR_CYCLES: rd_mux = DATA_W'(cycle_cnt);
            default:     rd_mux = '0;
        endcase
    end

    // Writable registers and free-running counter; a clear write beats the increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            LEDR      <= '0;
            hex_reg   <= '0;
            cycle_cnt <= '0;
        end else begin
            if (io_write && (mem_addr == ADDR_LEDR)) begin
                LEDR <= write_data[LED_W-1:0];
            end
            if (io_write && (mem_addr == ADDR_HEX)) begin
                hex_reg <= write_data;
            end
            if (io_write && (mem_addr == ADDR_CYCLES)) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

    // Response FSM: a read in either state captures data and (re)enters RESP,
    // so back-to-back reads keep rd_valid high. read_data holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            rd_valid  <= 1'b0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_read) begin
                        state     <= RESP;
                        rd_valid  <= 1'b1;
                        read_data <= rd_mux;
                    end else begin
                        rd_valid  <= 1'b0;
                    end
                end
                RESP: begin
                    if (io_read) begin
                        state     <= RESP;
                        rd_valid  <= 1'b1;
                        read_data <= rd_mux;
                    end else begin
                        state     <= IDLE;
                        rd_valid  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MMIO_HEX_DECODE_EN
    // Glyphs are registered alongside hex_reg so they change on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            HEX0 <= seg7_decode(4'h0);
            HEX1 <= seg7_decode(4'h0);
            HEX2 <= seg7_decode(4'h0);
            HEX3 <= seg7_decode(4'h0);
        end else if (io_write && (mem_addr == ADDR_HEX)) begin
            HEX0 <= seg7_decode(write_data[3:0]);
            HEX1 <= seg7_decode(write_data[7:4]);
            HEX2 <= seg7_decode(write_data[11:8]);
            HEX3 <= seg7_decode(write_data[15:12]);
        end
    end
`else
    assign HEX0 = SEG_BLANK;
    assign HEX1 = SEG_BLANK;
    assign HEX2 = SEG_BLANK;
    assign HEX3 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed and randomized stimulus for mmio_responder,
// compared each cycle against a register-level behavioural model.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  SW;
    logic [15:0] read_data;
    logic        io_sel;
    logic        rd_valid;
    logic [7:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    always #5 clk = ~clk;

    mmio_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .write_data(write_data),
        .SW        (SW),
        .read_data (read_data),
        .io_sel    (io_sel),
        .rd_valid  (rd_valid),
        .LEDR      (LEDR),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3)
    );

    // Active-low glyphs {g,f,e,d,c,b,a} for 0..F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0]  m_led;
    logic [15:0] m_hex;
    logic [15:0] m_cnt;
    logic [7:0]  m_stable;
    logic        m_rdv;
    logic [15:0] m_rdata;
    logic [7:0]  m_hist [6];   // SW seen at the last six edges, [5] newest

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_hex(input int i);
`ifdef MMIO_HEX_DECODE_EN
        return GLYPH[m_hex[i*4 +: 4]];
`else
        return 7'h7F;
`endif
    endfunction

    function automatic logic [15:0] model_read(input logic [8:0] a);
        case (a)
            9'h100:  return {8'h00, m_led};
            9'h120:  return m_hex;
            9'h140:  return {8'h00, m_stable};
            9'h180:  return m_cnt;
            default: return 16'h0000;
        endcase
    endfunction

    // Effect of one clock edge given the inputs present at that edge.
    task automatic model_edge(input logic rst_v, input logic [1:0] cmd, input logic [8:0] a,
                              input logic [15:0] wd, input logic [7:0] sw);
        logic wr;
        if (!rst_v) begin
            m_led = '0; m_hex = '0; m_cnt = '0; m_stable = '0;
            m_rdv = 1'b0; m_rdata = '0;
            for (int i = 0; i < 6; i++) m_hist[i] = '0;
        end else begin
            if (cmd == C_READ && a[8]) begin
                m_rdv   = 1'b1;
                m_rdata = model_read(a);
            end else begin
                m_rdv = 1'b0;
            end
            wr = (cmd == C_WRITE) && a[8];
            if (wr && a == 9'h100) m_led = wd[7:0];
            if (wr && a == 9'h120) m_hex = wd;
            m_cnt = (wr && a == 9'h180) ? 16'h0000 : m_cnt + 16'h0001;
            for (int i = 0; i < 5; i++) m_hist[i] = m_hist[i+1];
            m_hist[5] = sw;
            // Accept once four consecutive synchronised samples agree.
            if (m_hist[0] == m_hist[1] && m_hist[1] == m_hist[2] && m_hist[2] == m_hist[3])
                m_stable = m_hist[3];
        end
    endtask

    task automatic step(input logic rst_v, input logic [1:0] cmd, input logic [8:0] a,
                        input logic [15:0] wd, input logic [7:0] sw, input bit chk);
        reset_n    = rst_v;
        mem_cmd    = cmd;
        mem_addr   = a;
        write_data = wd;
        SW         = sw;
        #1;
        if (chk) check_val("io_sel", 32'(io_sel), 32'(a[8]));
        @(posedge clk);
        model_edge(rst_v, cmd, a, wd, sw);
        #1;
        if (chk) begin
            check_val("rd_valid", 32'(rd_valid), 32'(m_rdv));
            check_val("read_data", 32'(read_data), 32'(m_rdata));
            check_val("LEDR", 32'(LEDR), 32'(m_led));
            check_val("HEX0", 32'(HEX0), 32'(exp_hex(0)));
            check_val("HEX1", 32'(HEX1), 32'(exp_hex(1)));
            check_val("HEX2", 32'(HEX2), 32'(exp_hex(2)));
            check_val("HEX3", 32'(HEX3), 32'(exp_hex(3)));
        end
    endtask

    logic [8:0]  ra;
    logic [7:0]  rsw;
    logic [6:0]  blank_or_glyph [4];
    int          guard;

    initial begin
        m_led = '0; m_hex = '0; m_cnt = '0; m_stable = '0; m_rdv = 1'b0; m_rdata = '0;
        for (int i = 0; i < 6; i++) m_hist[i] = '0;

        // Reset
        step(1'b0, C_NONE, 9'h000, 16'h0, 8'h00, 1'b1);
        check_val("rst_rd_valid", 32'(rd_valid), 32'h0);
        check_val("rst_read_data", 32'(read_data), 32'h0);
        check_val("rst_LEDR", 32'(LEDR), 32'h0);
`ifdef MMIO_HEX_DECODE_EN
        check_val("rst_HEX0", 32'(HEX0), 32'h40);
`else
        check_val("rst_HEX0", 32'(HEX0), 32'h7F);
`endif
        repeat (8) step(1'b1, C_NONE, 9'h000, 16'h0, 8'h00, 1'b1);

        // LED write and readback
        step(1'b1, C_WRITE, 9'h100, 16'h00A5, 8'h00, 1'b1);
        check_val("led_write", 32'(LEDR), 32'hA5);
        step(1'b1, C_READ, 9'h100, 16'h0, 8'h00, 1'b1);
        check_val("led_rd_valid", 32'(rd_valid), 32'h1);
        check_val("led_rd_data", 32'(read_data), 32'h00A5);
        step(1'b1, C_NONE, 9'h000, 16'h0, 8'h00, 1'b1);
        check_val("led_rd_pulse", 32'(rd_valid), 32'h0);
        check_val("led_rd_hold", 32'(read_data), 32'h00A5);

        // Switch debounce with glitch
        repeat (3) step(1'b1, C_READ, 9'h140, 16'h0, 8'h3C, 1'b1);
        repeat (2) step(1'b1, C_READ, 9'h140, 16'h0, 8'h00, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            step(1'b1, C_READ, 9'h140, 16'h0, 8'h3C, 1'b1);
            if (j == 6) check_val("sw_not_yet", 32'(read_data), 32'h0000);
            if (j == 7) check_val("sw_settled", 32'(read_data), 32'h003C);
        end

        // HEX write
        step(1'b1, C_WRITE, 9'h120, 16'h1F80, 8'h3C, 1'b1);
`ifdef MMIO_HEX_DECODE_EN
        blank_or_glyph = '{7'h40, 7'h00, 7'h0E, 7'h79};
`else
        blank_or_glyph = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
        check_val("hex_d0", 32'(HEX0), 32'(blank_or_glyph[0]));
        check_val("hex_d1", 32'(HEX1), 32'(blank_or_glyph[1]));
        check_val("hex_d2", 32'(HEX2), 32'(blank_or_glyph[2]));
        check_val("hex_d3", 32'(HEX3), 32'(blank_or_glyph[3]));
        step(1'b1, C_READ, 9'h120, 16'h0, 8'h3C, 1'b1);
        check_val("hex_readback", 32'(read_data), 32'h1F80);

        // Counter clear beats increment; back-to-back reads after the clear
        step(1'b1, C_WRITE, 9'h180, 16'hFFFF, 8'h3C, 1'b1);
        step(1'b1, C_READ, 9'h180, 16'h0, 8'h3C, 1'b1);
        check_val("cnt_after_clear", 32'(read_data), 32'h0000);
        step(1'b1, C_READ, 9'h180, 16'h0, 8'h3C, 1'b1);
        check_val("cnt_one_later", 32'(read_data), 32'h0001);
        check_val("cnt_b2b_valid", 32'(rd_valid), 32'h1);

        // Run the counter up to the wrap point (bounded)
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            step(1'b1, C_NONE, 9'h000, 16'h0, 8'h3C, 1'b0);
            guard++;
        end
        check_val("wrap_reach", 32'(m_cnt), 32'hFFFF);
        step(1'b1, C_READ, 9'h180, 16'h0, 8'h3C, 1'b1);
        check_val("cnt_ffff", 32'(read_data), 32'hFFFF);
        step(1'b1, C_READ, 9'h180, 16'h0, 8'h3C, 1'b1);
        check_val("cnt_wrap", 32'(read_data), 32'h0000);

        // Back-to-back different registers
        step(1'b1, C_READ, 9'h100, 16'h0, 8'h3C, 1'b1);
        check_val("b2b_led", 32'(read_data), 32'h00A5);
        step(1'b1, C_READ, 9'h140, 16'h0, 8'h3C, 1'b1);
        check_val("b2b_sw", 32'(read_data), 32'h003C);
        check_val("b2b_valid", 32'(rd_valid), 32'h1);

        // Unmapped read, then reset in the middle of a response
        step(1'b1, C_READ, 9'h1FF, 16'h0, 8'h3C, 1'b1);
        check_val("unmapped", 32'(read_data), 32'h0000);
        step(1'b1, C_READ, 9'h100, 16'h0, 8'h3C, 1'b1);
        step(1'b0, C_READ, 9'h100, 16'h0, 8'h3C, 1'b1);
        check_val("rst_mid_resp", 32'(rd_valid), 32'h0);
        check_val("rst_led_clear", 32'(LEDR), 32'h0);

        // Randomized traffic
        rsw = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0:       ra = 9'h100;
                1:       ra = 9'h120;
                2:       ra = 9'h140;
                3:       ra = 9'h180;
                4:       ra = {1'b1, 8'($urandom)};
                default: ra = {1'b0, 8'($urandom)};
            endcase
            if ($urandom_range(0, 7) == 0) rsw = 8'($urandom);
            step(($urandom_range(0, 299) != 0), 2'($urandom_range(0, 3)), ra,
                 16'($urandom), rsw, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
